// File: rtl/nios_pio_freq_bank.sv
// Avalon-MM bank of NCH shadowed frequency/phase words with an atomic commit, optionally synchronised to sync_in.
// Define NIOS_PIO_FREQ_BANK_RAMP_EN to slew active words toward their targets by RAMP_STEP per cycle instead of jumping.
module nios_pio_freq_bank #(
  parameter int          NCH         = 2,
  parameter int          WIDTH       = 22,
  parameter logic [31:0] RESET_VALUE = 32'd593410,
  parameter int          ADDR_W      = 4
`ifdef NIOS_PIO_FREQ_BANK_RAMP_EN
  ,
  parameter int          RAMP_STEP   = 1024
`endif
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [ADDR_W-1:0]      address,
  input  logic                   chipselect,
  input  logic                   write_n,
  input  logic [31:0]            writedata,
  input  logic                   sync_in,
  output logic [31:0]            readdata,
  output logic [NCH*WIDTH-1:0]   out_port,
  output logic                   update,
  output logic                   busy
);

  localparam logic [WIDTH-1:0]  RST_WORD  = RESET_VALUE[WIDTH-1:0];
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NCH);
  localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(NCH + 1);

`ifdef NIOS_PIO_FREQ_BANK_RAMP_EN
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RAMP} state_t;
  localparam state_t S_GO = S_RAMP;
`else
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_APPLY} state_t;
  localparam state_t S_GO = S_APPLY;
`endif

  logic                        wr;
  logic                        ctrl_wr;
  logic                        go;
  logic                        armed;
  logic                        unused_wd;
  logic [NCH-1:0][WIDTH-1:0]   shadow_q;
  logic [NCH-1:0][WIDTH-1:0]   active_q;
  logic                        sync_mode_q;
  logic                        commit_q;
  logic                        abort_q;
  logic                        sync_q;
  logic                        update_q;
  state_t                      state_q;

  assign wr        = chipselect & ~write_n;
  assign ctrl_wr   = wr && (address == CTRL_ADDR);
  assign unused_wd = ^writedata;
  assign out_port  = active_q;
  assign update    = update_q;
  assign armed     = (state_q == S_ARMED);

`ifdef NIOS_PIO_FREQ_BANK_RAMP_EN
  logic [NCH-1:0][WIDTH-1:0] target_q;
  logic [NCH-1:0][WIDTH-1:0] ramp_d;

  assign busy = (state_q == S_ARMED) || (state_q == S_RAMP);

  // Clamp each move to the remaining distance so a channel never overshoots or wraps.
  always_comb begin
    ramp_d = target_q;
    for (int k = 0; k < NCH; k++) begin
      if (active_q[k] < target_q[k]) begin
        if (33'(target_q[k] - active_q[k]) > 33'(RAMP_STEP))
          ramp_d[k] = active_q[k] + WIDTH'(RAMP_STEP);
      end else if (active_q[k] > target_q[k]) begin
        if (33'(active_q[k] - target_q[k]) > 33'(RAMP_STEP))
          ramp_d[k] = active_q[k] - WIDTH'(RAMP_STEP);
      end
    end
  end
`else
  assign busy = (state_q == S_ARMED);
`endif

  // Control strobes are registered first, so a sync_in coinciding with the arming write is not seen by IDLE.
  always_comb begin
    go = 1'b0;
    case (state_q)
      S_IDLE:  go = commit_q & ~sync_mode_q;
      S_ARMED: go = ~abort_q & ((commit_q & ~sync_mode_q) | sync_q);
      default: go = 1'b0;
    endcase
  end

  always_comb begin
    readdata = '0;
    for (int k = 0; k < NCH; k++) begin
      if (address == ADDR_W'(k)) readdata = 32'(shadow_q[k]);
    end
    if (address == CTRL_ADDR)      readdata = {30'b0, sync_mode_q, 1'b0};
    else if (address == STAT_ADDR) readdata = {30'b0, busy, armed};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NCH; k++) begin
        shadow_q[k] <= RST_WORD;
        active_q[k] <= RST_WORD;
`ifdef NIOS_PIO_FREQ_BANK_RAMP_EN
        target_q[k] <= RST_WORD;
`endif
      end
      sync_mode_q <= 1'b0;
      commit_q    <= 1'b0;
      abort_q     <= 1'b0;
      sync_q      <= 1'b0;
      update_q    <= 1'b0;
      state_q     <= S_IDLE;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (wr && (address == ADDR_W'(k))) shadow_q[k] <= writedata[WIDTH-1:0];
      end
      if (ctrl_wr) sync_mode_q <= writedata[1];
      commit_q <= ctrl_wr & writedata[0];
      abort_q  <= ctrl_wr & writedata[2];
      sync_q   <= sync_in;
      update_q <= 1'b0;
`ifdef NIOS_PIO_FREQ_BANK_RAMP_EN
      if (go) target_q <= shadow_q;
`endif
      case (state_q)
        S_IDLE: begin
          if (go)            state_q <= S_GO;
          else if (commit_q) state_q <= S_ARMED;
        end
        S_ARMED: begin
          if (abort_q)       state_q <= S_IDLE;
          else if (go)       state_q <= S_GO;
        end
`ifdef NIOS_PIO_FREQ_BANK_RAMP_EN
        S_RAMP: begin
          active_q <= ramp_d;
          if (ramp_d == target_q) begin
            update_q <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
`else
        S_APPLY: begin
          active_q <= shadow_q;
          update_q <= 1'b1;
          state_q  <= S_IDLE;
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_pio_freq_bank.sv
// Directed bench for nios_pio_freq_bank: reset, immediate/sync/abort commits, reset while armed, and ramp when enabled.
module tb_nios_pio_freq_bank;
  localparam logic [21:0] RV = 22'd593410;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic        sync_in = 1'b0;
  logic [31:0] readdata;
  logic [43:0] out_port;
  logic        update;
  logic        busy;

  int          checks = 0;
  int          failures = 0;
  logic [43:0] exp_out;
  logic        seen;

  nios_pio_freq_bank #(.NCH(2), .WIDTH(22), .RESET_VALUE(32'd593410), .ADDR_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .sync_in(sync_in), .readdata(readdata),
    .out_port(out_port), .update(update), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic s);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0; sync_in = s;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; sync_in = 1'b0;
    $display("write addr=%0d data=%h sync=%0b", a, d, s);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_sync();
    @(negedge clk); sync_in = 1'b1;
    @(negedge clk); sync_in = 1'b0;
    $display("sync_in pulse");
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(2);
    checks++; if (out_port !== {RV, RV}) begin failures++; $display("FAIL reset_out got=%h exp=%h", out_port, {RV, RV}); end
    checks++; if (busy !== 1'b0 || update !== 1'b0) begin failures++; $display("FAIL reset_flags busy=%b update=%b exp=0", busy, update); end
    address = 4'd0; #1;
    checks++; if (readdata !== 32'd593410) begin failures++; $display("FAIL reset_rd0 got=%h exp=%h", readdata, 32'd593410); end
    address = 4'd2; #1;
    checks++; if (readdata !== 32'd0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", readdata); end
    address = 4'd5; #1;
    checks++; if (readdata !== 32'd0) begin failures++; $display("FAIL unmapped_rd got=%h exp=0", readdata); end
    reset_n = 1'b1;
    exp_out = {RV, RV};
    tick(1);
    $display("reset done");
  endtask

  task automatic test_immediate();
    wr(4'd0, 32'h1000, 1'b0);
    wr(4'd1, 32'h2000, 1'b0);
    checks++; if (out_port !== {RV, RV}) begin failures++; $display("FAIL shadow_no_effect got=%h exp=%h", out_port, {RV, RV}); end
    address = 4'd0; #1;
    checks++; if (readdata !== 32'h1000) begin failures++; $display("FAIL shadow_rd got=%h exp=%h", readdata, 32'h1000); end
    wr(4'd2, 32'h1, 1'b0);
    tick(1);
    checks++; if (out_port !== {RV, RV} || update !== 1'b0) begin failures++; $display("FAIL imm_early out=%h update=%b exp=%h/0", out_port, update, {RV, RV}); end
    tick(1);
    exp_out = {22'h2000, 22'h1000};
    checks++; if (out_port !== exp_out || update !== 1'b1) begin failures++; $display("FAIL imm_apply out=%h update=%b exp=%h/1", out_port, update, exp_out); end
    tick(1);
    checks++; if (update !== 1'b0) begin failures++; $display("FAIL imm_update_width got=%b exp=0", update); end
    $display("immediate commit out=%h", out_port);
  endtask

  task automatic test_sync();
    wr(4'd0, 32'h3333, 1'b0);
    wr(4'd1, 32'h4444, 1'b0);
    wr(4'd2, 32'h3, 1'b0);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sync_busy_early got=%b exp=0", busy); end
    tick(1);
    address = 4'd3; #1;
    checks++; if (readdata !== 32'h3 || busy !== 1'b1) begin failures++; $display("FAIL armed_status got=%h busy=%b exp=3/1", readdata, busy); end
    address = 4'd2; #1;
    checks++; if (readdata !== 32'h2) begin failures++; $display("FAIL ctrl_rd got=%h exp=2", readdata); end
    wr(4'd1, 32'h5555, 1'b0);
    tick(8);
    checks++; if (busy !== 1'b1 || out_port !== exp_out) begin failures++; $display("FAIL armed_hold busy=%b out=%h exp=1/%h", busy, out_port, exp_out); end
    pulse_sync();
    checks++; if (busy !== 1'b1 || out_port !== exp_out) begin failures++; $display("FAIL sync_s0 busy=%b out=%h exp=1/%h", busy, out_port, exp_out); end
    tick(1);
    checks++; if (out_port !== exp_out || update !== 1'b0) begin failures++; $display("FAIL sync_s1 out=%h update=%b exp=%h/0", out_port, update, exp_out); end
    tick(1);
    exp_out = {22'h5555, 22'h3333};
    checks++; if (out_port !== exp_out || update !== 1'b1) begin failures++; $display("FAIL sync_apply out=%h update=%b exp=%h/1", out_port, update, exp_out); end
    $display("sync commit out=%h", out_port);
  endtask

  task automatic test_abort();
    wr(4'd0, 32'h7777, 1'b0);
    wr(4'd2, 32'h3, 1'b0);
    tick(2);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_armed got=%b exp=1", busy); end
    wr(4'd2, 32'h6, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (update !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_update got=1 exp=0"); end
    checks++; if (busy !== 1'b0 || out_port !== exp_out) begin failures++; $display("FAIL abort_state busy=%b out=%h exp=0/%h", busy, out_port, exp_out); end
    address = 4'd2; #1;
    checks++; if (readdata !== 32'h2) begin failures++; $display("FAIL abort_ctrl got=%h exp=2", readdata); end
    $display("abort out=%h", out_port);
  endtask

  task automatic test_armed_immediate();
    wr(4'd2, 32'h3, 1'b0);
    tick(1);
    wr(4'd2, 32'h1, 1'b0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL armimm_busy got=%b exp=1", busy); end
    tick(1);
    checks++; if (busy !== 1'b0 || out_port !== exp_out) begin failures++; $display("FAIL armimm_early busy=%b out=%h exp=0/%h", busy, out_port, exp_out); end
    tick(1);
    exp_out = {22'h5555, 22'h7777};
    checks++; if (out_port !== exp_out || update !== 1'b1) begin failures++; $display("FAIL armimm_apply out=%h update=%b exp=%h/1", out_port, update, exp_out); end
    $display("armed immediate commit out=%h", out_port);
  endtask

  task automatic test_status_write();
    wr(4'd3, 32'hFFFF_FFFF, 1'b0);
    tick(2);
    address = 4'd3; #1;
    checks++; if (readdata !== 32'h0 || busy !== 1'b0 || update !== 1'b0) begin failures++; $display("FAIL status_wr rd=%h busy=%b update=%b exp=0", readdata, busy, update); end
    checks++; if (out_port !== exp_out) begin failures++; $display("FAIL status_wr_out got=%h exp=%h", out_port, exp_out); end
    $display("status write ignored");
  endtask

  task automatic test_reset_mid_armed();
    wr(4'd0, 32'h1234, 1'b0);
    wr(4'd2, 32'h3, 1'b0);
    tick(1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rma_armed got=%b exp=1", busy); end
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    exp_out = {RV, RV};
    checks++; if (out_port !== exp_out || busy !== 1'b0) begin failures++; $display("FAIL rma_reset out=%h busy=%b exp=%h/0", out_port, busy, exp_out); end
    address = 4'd2; #1;
    checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL rma_ctrl got=%h exp=0", readdata); end
    pulse_sync();
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (update !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0 || out_port !== exp_out) begin failures++; $display("FAIL rma_after update_seen=%b out=%h exp=0/%h", seen, out_port, exp_out); end
    $display("reset mid-armed out=%h", out_port);
  endtask

`ifdef NIOS_PIO_FREQ_BANK_RAMP_EN
  task automatic test_ramp();
    wr(4'd0, 32'd595910, 1'b0);
    wr(4'd2, 32'h1, 1'b0);
    checks++; if (out_port !== {RV, RV} || busy !== 1'b0) begin failures++; $display("FAIL ramp_n0 out=%h busy=%b", out_port, busy); end
    tick(1);
    checks++; if (out_port !== {RV, RV} || busy !== 1'b1) begin failures++; $display("FAIL ramp_entry out=%h busy=%b exp=%h/1", out_port, busy, {RV, RV}); end
    tick(1);
    checks++; if (out_port !== {RV, 22'd594434} || update !== 1'b0) begin failures++; $display("FAIL ramp_step1 out=%h update=%b", out_port, update); end
    tick(1);
    checks++; if (out_port !== {RV, 22'd595458} || update !== 1'b0) begin failures++; $display("FAIL ramp_step2 out=%h update=%b", out_port, update); end
    tick(1);
    exp_out = {RV, 22'd595910};
    checks++; if (out_port !== exp_out || update !== 1'b1) begin failures++; $display("FAIL ramp_step3 out=%h update=%b exp=%h/1", out_port, update, exp_out); end
    tick(1);
    checks++; if (busy !== 1'b0 || update !== 1'b0) begin failures++; $display("FAIL ramp_done busy=%b update=%b exp=0/0", busy, update); end
    $display("ramp out=%h", out_port);
  endtask
`endif

  initial begin
    exp_out = '0;
    seen = 1'b0;
    test_reset();
`ifdef NIOS_PIO_FREQ_BANK_RAMP_EN
    test_ramp();
    test_abort();
`else
    test_immediate();
    test_sync();
    test_abort();
    test_armed_immediate();
    test_status_write();
`endif
    test_reset_mid_armed();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
